room_text_pager: RTL

Controller that sequences the combinational room-text ROM (`labyrinth_rom`) for a small character display. When a new player position arrives, it latches it and sweeps the ROM's 256-character description one page at a time. Each character is handed downstream over a valid/ready stream with its in-page address. It then waits for the player to request the next page. Sits between the game-state logic and the LCD/text-buffer writer; the ROM instance lives in the parent and is addressed by this block.

---
 rtl/zork_text_pkg.sv | 22 ++
 rtl/room_text_pager.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/zork_text_pkg.sv
// Shared types and constants for the room-text pager.
//   pager_state_t : pager sequencing states
//   CHAR_SPACE    : blank character held on the output while idle
//   ROOM_TEXT_LEN : characters in one room description
//   page_count()  : number of display pages per room description
package zork_text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_WAIT_NEXT
  } pager_state_t;

  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam int         ROOM_TEXT_LEN = 256;

  function automatic int page_count(input int page_chars);
    return ROOM_TEXT_LEN / page_chars;
  endfunction

endpackage

// File: rtl/room_text_pager.sv
// Room-text pager: latches a player position, sweeps the combinational
// room-text ROM one display page at a time and hands each character
// downstream over a valid/ready stream.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   player_pos       room coordinate, sampled when pos_valid=1
//   pos_valid        new room entered: restart at page 0 (top priority)
//   page_next        advance to the next page (honoured only in WAIT_NEXT)
//   rom_player_pos   latched position, to the ROM
//   rom_screen_pos   ROM character index {page_idx, offset}
//   rom_char         ROM character, combinational from the two above
//   char_data/addr   registered character and its position in the page
//   char_valid       char_data/char_addr valid
//   char_ready       downstream accepts (transfer when valid & ready)
//   page_done        one-cycle pulse after the last character of a page
//   page_idx         current page number
//   last_page        page_idx is the final page
//   busy             a page is being streamed
module room_text_pager
  import zork_text_pkg::*;
#(
  parameter  int PAGE_CHARS = 32,
  localparam int AW = $clog2(PAGE_CHARS),
  localparam int PW = (AW >= 8) ? 1 : 8 - AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    player_pos,
  input  logic          pos_valid,
  input  logic          page_next,
  output logic [7:0]    rom_player_pos,
  output logic [7:0]    rom_screen_pos,
  input  logic [7:0]    rom_char,
  output logic [7:0]    char_data,
  output logic [AW-1:0] char_addr,
  output logic          char_valid,
  input  logic          char_ready,
  output logic          page_done,
  output logic [PW-1:0] page_idx,
  output logic          last_page,
  output logic          busy
);

  localparam logic [PW-1:0] LAST_PAGE   = PW'(page_count(PAGE_CHARS) - 1);
  localparam logic [AW-1:0] LAST_OFFSET = AW'(PAGE_CHARS - 1);

  pager_state_t  state_reg,  state_next;
  logic [7:0]    pos_reg,    pos_next;
  logic [PW-1:0] page_reg,   page_idx_next;
  logic [AW-1:0] offset_reg, offset_next;
  logic [7:0]    data_reg,   data_next;
  logic [AW-1:0] addr_reg,   addr_next;
  logic          valid_reg,  valid_next;
  logic          done_reg,   done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      pos_reg    <= 8'h00;
      page_reg   <= '0;
      offset_reg <= '0;
      data_reg   <= CHAR_SPACE;
      addr_reg   <= '0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pos_reg    <= pos_next;
      page_reg   <= page_idx_next;
      offset_reg <= offset_next;
      data_reg   <= data_next;
      addr_reg   <= addr_next;
      valid_reg  <= valid_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pos_next      = pos_reg;
    page_idx_next = page_reg;
    offset_next   = offset_reg;
    data_next     = data_reg;
    addr_next     = addr_reg;
    valid_next    = valid_reg;
    done_next     = 1'b0;

    if (pos_valid) begin
      // A new room overrides everything; a pending character is dropped.
      pos_next      = player_pos;
      page_idx_next = '0;
      offset_next   = '0;
      valid_next    = 1'b0;
      state_next    = ST_STREAM;
    end else begin
      case (state_reg)
        ST_STREAM: begin
          // Output register is free when empty or being drained this cycle.
          if (!valid_reg || char_ready) begin
            data_next   = rom_char;
            addr_next   = offset_reg;
            valid_next  = 1'b1;
            offset_next = offset_reg + AW'(1);
            if (offset_reg == LAST_OFFSET) begin
              state_next = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (char_ready) begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = ST_WAIT_NEXT;
          end
        end
        ST_WAIT_NEXT: begin
          if (page_next && (page_reg != LAST_PAGE)) begin
            page_idx_next = page_reg + PW'(1);
            offset_next   = '0;
            state_next    = ST_STREAM;
          end
        end
        default: ;
      endcase
    end
  end

  // The ROM index comes straight from flops, so the ROM output settles
  // one cycle before it is loaded into the output register.
  generate
    if (AW >= 8) begin : g_single_page
      assign rom_screen_pos = 8'(offset_reg);
    end else begin : g_paged
      assign rom_screen_pos = {page_reg, offset_reg};
    end
  endgenerate

  assign rom_player_pos = pos_reg;
  assign char_data      = data_reg;
  assign char_addr      = addr_reg;
  assign char_valid     = valid_reg;
  assign page_done      = done_reg;
  assign page_idx       = page_reg;
  assign last_page      = (page_reg == LAST_PAGE);
  assign busy           = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);

endmodule
